// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1 - registered N_CH:1 channel multiplexer with direct and
// round-robin scan modes, producing a valid/ready stream tagged with the
// source channel index.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   data_in      packed channels, channel k = data_in[k*DW +: DW]
//   sel          channel select used in direct mode
//   mode         0 = direct, 1 = scan
//   enable       1 = captures allowed (0 forces IDLE)
//   ch_en        per-channel enable mask used in scan mode
//   dwell        idle cycles between scan samples
//   out_valid    output register holds a sample
//   out_ready    downstream accepts the sample
//   data_out     captured sample
//   ch_out       channel index of data_out
//   sel_err      sticky flag: direct-mode sel >= N_CH was seen
module mux_scan_nx1 #(
  parameter int N_CH    = 8,
  parameter int DW      = 8,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   data_in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_en,
  input  logic [DWELL_W-1:0]   dwell,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        data_out,
  output logic [SEL_W-1:0]     ch_out,
  output logic                 sel_err
);

  localparam int unsigned NCH_U = N_CH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN_LOAD,
    S_SCAN_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 capture;
  logic [SEL_W-1:0]     cap_ch;
  logic                 err_set;
  logic                 slot_free;
  logic                 sel_ok;
  logic [SEL_W-1:0]     lowest_en;
  logic [SEL_W-1:0]     next_en;
  logic [DW-1:0]        chan [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    always_comb chan[g] = data_in[g*DW +: DW];
  end

  // Out-of-range selects only exist when N_CH is not a power of two.
  if (N_CH == (1 << SEL_W)) begin : g_pow2
    always_comb sel_ok = 1'b1;
  end else begin : g_npow2
    always_comb sel_ok = (sel < SEL_W'(N_CH));
  end

  assign slot_free = !out_valid || out_ready;

  // Both searches scan downward so the last hit is the nearest candidate:
  // lowest set bit overall, and first set bit strictly above ptr (wrapping).
  always_comb begin
    int unsigned idx;
    lowest_en = '0;
    next_en   = ptr_q;
    for (int unsigned i = NCH_U; i > 0; i--) begin
      if (ch_en[SEL_W'(i - 1)]) lowest_en = SEL_W'(i - 1);
    end
    for (int unsigned i = NCH_U; i > 0; i--) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NCH_U) idx = idx - NCH_U;
      if (ch_en[SEL_W'(idx)]) next_en = SEL_W'(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    cap_ch  = ptr_q;
    err_set = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = mode ? S_SCAN_LOAD : S_DIRECT;
        S_DIRECT: begin
          if (mode) begin
            state_d = S_SCAN_LOAD;
          end else if (!sel_ok) begin
            err_set = 1'b1;
          end else if (slot_free) begin
            capture = 1'b1;
            cap_ch  = sel;
          end
        end
        S_SCAN_LOAD: begin
          if (!mode) begin
            state_d = S_DIRECT;
          end else if (ch_en != '0) begin
            ptr_d   = lowest_en;
            cnt_d   = dwell;
            state_d = S_SCAN_WAIT;
          end
        end
        S_SCAN_WAIT: begin
          if (!mode) begin
            state_d = S_DIRECT;
          end else if (ch_en == '0) begin
            state_d = S_SCAN_LOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (!ch_en[ptr_q]) begin
            ptr_d = next_en;
          end else if (slot_free) begin
            capture = 1'b1;
            cap_ch  = ptr_q;
            ptr_d   = next_en;
            cnt_d   = dwell;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      ch_out    <= '0;
      sel_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (err_set) sel_err <= 1'b1;
      if (capture) begin
        out_valid <= 1'b1;
        data_out  <= chan[cap_ch];
        ch_out    <= cap_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
